// File: rtl/amo_resp_if.sv
// ============================================================================
// Module      : amo_resp_if
// Description : Memory-stage micro-op, cache and snoop bundle for amo_resp.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface amo_resp_if;
    logic        stall;
    logic        mem_vld;
    logic [31:0] mem_ir;
    logic [63:0] mem_addr;
    logic        amo_req;
    logic        lr_req;
    logic        sc_req;
    logic        dc_done;
    logic        snoop_vld;
    logic [63:0] snoop_addr;
    logic        amo_ack;
    logic        dc_lock;
    logic        amo_busy;
    logic        amo_err;
    logic        sc_fail;

    modport master (
        output stall, mem_vld, mem_ir, mem_addr, amo_req, lr_req, sc_req,
               dc_done, snoop_vld, snoop_addr,
        input  amo_ack, dc_lock, amo_busy, amo_err, sc_fail
    );

    modport slave (
        input  stall, mem_vld, mem_ir, mem_addr, amo_req, lr_req, sc_req,
               dc_done, snoop_vld, snoop_addr,
        output amo_ack, dc_lock, amo_busy, amo_err, sc_fail
    );
endinterface

`default_nettype wire

// File: rtl/amo_resp.sv
// ============================================================================
// Module      : amo_resp
// Description : AMO load/ALU/store sequence responder with cache lock,
//               timeout abort and LR/SC reservation tracking.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module amo_resp #(
    parameter int TIMEOUT  = 64,
    parameter int RSV_GRAN = 3
) (
    input  wire logic   clk,
    input  wire logic   rst_n,
    amo_resp_if.slave   bus
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_LD   = 2'd1;
    localparam logic [1:0] c_NEXT = 2'd2;
    localparam logic [1:0] c_ST   = 2'd3;

    localparam logic [6:0] c_OP_LOAD  = 7'b0000011;
    localparam logic [6:0] c_OP_ALU   = 7'b0110011;
    localparam logic [6:0] c_OP_STORE = 7'b0100011;

    localparam int               c_CNT_W    = $clog2(TIMEOUT) + 1;
    localparam logic [c_CNT_W-1:0] c_TMO_LAST = c_CNT_W'(TIMEOUT - 1);

    logic [1:0]          r_state;
    logic [1:0]          w_state_nxt;
    logic                r_op_seen;
    logic                r_ack_pend;
    logic [63:0]         r_lock_addr;
    logic [c_CNT_W-1:0]  r_cnt;
    logic                r_rsv_vld;
    logic [63:RSV_GRAN]  r_rsv_addr;

    logic        w_step;
    logic        w_flush;
    logic        w_tmo;
    logic [6:0]  w_opc;
    logic        w_abort;
    logic        w_complete;
    logic        w_ack;
    logic        w_set_seen;
    logic        w_clr_seen;
    logic        w_latch_addr;
    logic        w_rsv_hit_mem;
    logic        w_snoop_hit;
    logic        w_unused;

    assign w_opc   = bus.mem_ir[6:0];
    assign w_step  = bus.mem_vld & bus.amo_req;
    assign w_flush = bus.mem_vld & ~bus.amo_req;
    assign w_tmo   = (r_cnt == c_TMO_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Stall freezes every transition; only a completion (dc_done or the
    // first ALU step) is still recognised so its ack can be held.
    always_comb begin
        w_state_nxt  = r_state;
        w_abort      = 1'b0;
        w_complete   = 1'b0;
        w_set_seen   = 1'b0;
        w_clr_seen   = 1'b0;
        w_latch_addr = 1'b0;
        case (r_state)
            c_IDLE: begin
                if (w_step && !bus.stall) begin
                    if (w_opc == c_OP_LOAD) begin
                        w_state_nxt  = c_LD;
                        w_latch_addr = 1'b1;
                    end else begin
                        w_abort = 1'b1;
                    end
                end
            end
            c_LD: begin
                w_complete = bus.dc_done | r_ack_pend;
                if (!bus.stall) begin
                    if (w_flush || w_tmo) begin
                        w_abort = 1'b1;
                    end else if (w_complete) begin
                        w_state_nxt = c_NEXT;
                    end
                end
            end
            c_NEXT: begin
                w_complete = r_ack_pend | (w_step && (w_opc == c_OP_ALU) && !r_op_seen);
                if (!bus.stall) begin
                    if (w_flush || w_tmo) begin
                        w_abort = 1'b1;
                    end else if (w_complete) begin
                        w_set_seen = 1'b1;
                    end else if (w_step && (w_opc == c_OP_ALU)) begin
                        w_abort = 1'b1;
                    end else if (w_step && (w_opc == c_OP_STORE)) begin
                        if (bus.mem_addr == r_lock_addr) begin
                            w_state_nxt = c_ST;
                        end else begin
                            w_abort = 1'b1;
                        end
                    end
                end
            end
            default: begin
                w_complete = bus.dc_done | r_ack_pend;
                if (!bus.stall) begin
                    if (w_flush || w_tmo) begin
                        w_abort = 1'b1;
                    end else if (w_complete) begin
                        w_state_nxt = c_IDLE;
                        w_clr_seen  = 1'b1;
                    end
                end
            end
        endcase
        if (w_abort) begin
            w_state_nxt = c_IDLE;
            w_clr_seen  = 1'b1;
        end
    end

    assign w_ack = w_complete & ~w_abort;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op_seen   <= 1'b0;
            r_ack_pend  <= 1'b0;
            r_lock_addr <= '0;
            r_cnt       <= '0;
        end else begin
            r_ack_pend <= bus.stall & w_ack;
            if (w_clr_seen) begin
                r_op_seen <= 1'b0;
            end else if (w_set_seen) begin
                r_op_seen <= 1'b1;
            end
            if (w_latch_addr) begin
                r_lock_addr <= bus.mem_addr;
            end
            if ((r_state == c_IDLE) || w_ack || w_abort) begin
                r_cnt <= '0;
            end else if (!bus.stall) begin
                r_cnt <= r_cnt + c_CNT_W'(1);
            end
        end
    end

    // Reservation: a same-cycle lr beats a snoop, an abort beats everything.
    assign w_rsv_hit_mem = r_rsv_vld & (bus.mem_addr[63:RSV_GRAN] == r_rsv_addr);
    assign w_snoop_hit   = bus.snoop_vld & r_rsv_vld & (bus.snoop_addr[63:RSV_GRAN] == r_rsv_addr);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsv_vld  <= 1'b0;
            r_rsv_addr <= '0;
        end else begin
            if (w_abort) begin
                r_rsv_vld <= 1'b0;
            end else if (bus.mem_vld && bus.lr_req && bus.dc_done) begin
                r_rsv_vld  <= 1'b1;
                r_rsv_addr <= bus.mem_addr[63:RSV_GRAN];
            end else if (w_snoop_hit || (bus.mem_vld && bus.sc_req && bus.dc_done)) begin
                r_rsv_vld <= 1'b0;
            end
        end
    end

    assign bus.amo_ack  = rst_n & w_ack;
    assign bus.amo_err  = rst_n & w_abort;
    assign bus.amo_busy = (r_state != c_IDLE);
    assign bus.dc_lock  = rst_n & ((r_state != c_IDLE) | (w_step & (w_opc == c_OP_LOAD)));
    assign bus.sc_fail  = rst_n & bus.mem_vld & bus.sc_req & ~(w_rsv_hit_mem & ~w_snoop_hit);

    assign w_unused = &{1'b0, bus.mem_ir[31:7], bus.snoop_addr[RSV_GRAN-1:0]};

endmodule

`default_nettype wire
